// File: rtl/fsm_arb_pkg.sv
// Shared encodings for the round-robin / fixed-priority grant arbiter.
// State, mode and hold-counter width constants used by fsm_arb_rr and its picker.
package fsm_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/fsm_arb_rr_prio_pick.sv
// Combinational priority pick: first set bit of req, searching upward from start with wrap.
// Zero latency; no flow control, found=0 when req is empty.
module arb_prio_pick #(
  parameter int N    = 4,
  parameter int IDW  = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // start is always < N, so (start + i) % N visits every requester exactly once
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(start) + i) % N]) begin
        found = 1'b1;
        idx   = IDW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fsm_arb_rr.sv
// N-requester grant arbiter with fixed/round-robin selection and bounded grant hold.
// Latency req->gnt one edge; every release inserts one idle cycle; no preemption while granted.
module fsm_arb_rr
  import fsm_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_valid,
  output logic                       timeout
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [0:0]         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] skip_mask;

  logic [NUM_REQ-1:0] req_unmasked;
  logic [NUM_REQ-1:0] req_eff;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    start;
  logic               found;
  logic [ID_W-1:0]    win;
  logic               hold_expired;

  // A timed-out owner is skipped only while someone else is asking.
  always_comb begin
    req_unmasked = req & ~skip_mask;
    req_eff      = (req_unmasked != '0) ? req_unmasked : req;
    rr_next      = (rr_ptr == ID_W'(NUM_REQ - 1)) ? '0 : rr_ptr + 1'b1;
    start        = (mode == MODE_RR) ? rr_next : '0;
  end

  arb_prio_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req   (req_eff),
    .start (start),
    .found (found),
    .idx   (win)
  );

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      skip_mask <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state     <= ST_GRANT;
            gnt       <= NUM_REQ'(1) << win;
            gnt_id    <= win;
            gnt_valid <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
            rr_ptr    <= win;
            skip_mask <= '0;
          end
        end
        ST_GRANT: begin
          if (!req[gnt_id]) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end else if (hold_expired) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            timeout   <= 1'b1;
            skip_mask <= gnt;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_arb_rr.sv
// Directed bench for fsm_arb_rr: MAX_HOLD=8 instance for arbitration/timeout,
// MAX_HOLD=0 instance for the unlimited-hold case.
module tb_fsm_arb_rr;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  logic       mode2 = 1'b0;
  logic [3:0] req2  = 4'b0000;
  logic [3:0] gnt2;
  logic [1:0] gnt_id2;
  logic       gnt_valid2;
  logic       timeout2;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clock = ~clock;

  fsm_arb_rr #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  fsm_arb_rr #(.NUM_REQ(4), .MAX_HOLD(0)) dut_nolimit (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode2),
    .req       (req2),
    .gnt       (gnt2),
    .gnt_id    (gnt_id2),
    .gnt_valid (gnt_valid2),
    .timeout   (timeout2)
  );

  // One rising edge, then settle; structural invariants are checked on both instances.
  task automatic tick();
    @(posedge clock);
    #1;
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || (gnt_valid !== (|gnt)) || (!gnt_valid && gnt_id !== 2'd0)) begin
        failures++;
        $display("FAIL invariant dut: gnt=%b gnt_valid=%b gnt_id=%0d, required one-hot/zero gnt, valid=|gnt, id=0 when idle",
                 gnt, gnt_valid, gnt_id);
      end
      checks++;
      if (!$onehot0(gnt2) || (gnt_valid2 !== (|gnt2)) || (!gnt_valid2 && gnt_id2 !== 2'd0)) begin
        failures++;
        $display("FAIL invariant dut_nolimit: gnt=%b gnt_valid=%b gnt_id=%0d, required one-hot/zero gnt, valid=|gnt, id=0 when idle",
                 gnt2, gnt_valid2, gnt_id2);
      end
    end
  endtask

  task automatic go_idle();
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mode  = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    mon_en = 1'b1;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++;
    if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    checks++;
    if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_gnt_valid: got %b want 0", gnt_valid); end
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    reset = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL first_grant: got %b want 0001", gnt); end
    checks++;
    if (gnt_valid !== 1'b1) begin failures++; $display("FAIL first_grant_valid: got %b want 1", gnt_valid); end
  endtask

  task automatic test_fixed_release();
    go_idle();
    mode = 1'b0;
    req  = 4'b0110;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
        failures++;
        $display("FAIL fixed_hold cycle %0d: got gnt=%b id=%0d want 0010 id=1", c, gnt, gnt_id);
      end
    end
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL fixed_release_idle: got %b want 0000", gnt); end
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL fixed_next_grant: got gnt=%b id=%0d want 0100 id=2", gnt, gnt_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt;
    go_idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mode  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << exp_order[k];
      req = 4'b1111;
      for (int c = 1; c <= 2; c++) begin
        tick();
        checks++;
        if (gnt !== exp_gnt || gnt_id !== 2'(exp_order[k])) begin
          failures++;
          $display("FAIL rr_grant k=%0d cycle %0d: got gnt=%b id=%0d want %b id=%0d",
                   k, c, gnt, gnt_id, exp_gnt, exp_order[k]);
        end
      end
      req = 4'b1111 & ~exp_gnt;
      tick();
      checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap k=%0d: got gnt=%b timeout=%b want 0000 timeout=0", k, gnt, timeout);
      end
    end
  endtask

  task automatic test_timeout_sole();
    logic [3:0] exp_gnt;
    logic       exp_to;
    go_idle();
    mode = 1'b1;
    req  = 4'b0001;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_to  = ((e - 1) % 9) == 8;
      exp_gnt = exp_to ? 4'b0000 : 4'b0001;
      checks++;
      if (gnt !== exp_gnt || timeout !== exp_to) begin
        failures++;
        $display("FAIL timeout_sole edge %0d: got gnt=%b timeout=%b want %b timeout=%b",
                 e, gnt, timeout, exp_gnt, exp_to);
      end
    end
  endtask

  task automatic test_timeout_skip();
    logic [3:0] exp_gnt;
    logic       exp_to;
    go_idle();
    mode = 1'b0;
    req  = 4'b0011;
    for (int e = 1; e <= 19; e++) begin
      tick();
      exp_to  = (e == 9) || (e == 18);
      if (exp_to)       exp_gnt = 4'b0000;
      else if (e < 9)   exp_gnt = 4'b0001;
      else if (e < 18)  exp_gnt = 4'b0010;
      else              exp_gnt = 4'b0001;
      checks++;
      if (gnt !== exp_gnt || timeout !== exp_to) begin
        failures++;
        $display("FAIL timeout_skip edge %0d: got gnt=%b timeout=%b want %b timeout=%b",
                 e, gnt, timeout, exp_gnt, exp_to);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    go_idle();
    mode = 1'b0;
    req  = 4'b0100;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL midreset_pre: got %b want 0100", gnt); end
    reset = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_drop: got gnt=%b valid=%b timeout=%b want 0000 0 0", gnt, gnt_valid, timeout);
    end
    reset = 1'b1;
    mode  = 1'b1;
    req   = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL midreset_rr_first: got gnt=%b id=%0d want 0001 id=0", gnt, gnt_id);
    end
  endtask

  task automatic test_no_preempt();
    go_idle();
    mode = 1'b0;
    req  = 4'b0100;
    tick();
    mode = 1'b1;
    req  = 4'b1111;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL no_preempt: got %b want 0100", gnt); end
    req = 4'b1011;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL no_preempt_release: got %b want 0000", gnt); end
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL rr_after_fixed: got gnt=%b id=%0d want 1000 id=3", gnt, gnt_id);
    end
  endtask

  task automatic test_unlimited_hold();
    int bad = 0;
    go_idle();
    mode2 = 1'b0;
    req2  = 4'b1000;
    tick();
    for (int e = 1; e <= 300; e++) begin
      tick();
      checks++;
      if (gnt2 !== 4'b1000 || timeout2 !== 1'b0) begin
        failures++;
        if (bad < 5)
          $display("FAIL unlimited_hold edge %0d: got gnt=%b timeout=%b want 1000 timeout=0", e, gnt2, timeout2);
        bad++;
      end
    end
    req2 = 4'b0000;
    tick();
    checks++;
    if (gnt2 !== 4'b0000) begin failures++; $display("FAIL unlimited_release: got %b want 0000", gnt2); end
  endtask

  initial begin
    test_reset();
    test_fixed_release();
    test_round_robin();
    test_timeout_sole();
    test_timeout_skip();
    test_reset_mid_grant();
    test_no_preempt();
    test_unlimited_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
